// File: rtl/cpu_ctrl.sv
// cpu_ctrl: multi-cycle fetch/decode/execute sequencer owning PC, IR and PSR.
// Define CPU_CTRL_MEM_TIMEOUT_EN to abort memory waits after MEM_TIMEOUT cycles and raise err.
module cpu_ctrl #(
  parameter int unsigned             DATAWIDTH   = 16,
  parameter int unsigned             REGWIDTH    = 4,
  parameter int unsigned             ALUOPWIDTH  = 4,
  parameter int unsigned             PSRWIDTH    = 5,
  parameter int unsigned             PSR_Z_BIT   = 3,
  parameter logic [DATAWIDTH-1:0]    RESET_PC    = 16'h0000,
  parameter int unsigned             MEM_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATAWIDTH-1:0]  mem_rdata,
  input  logic                  mem_ready,
  input  logic [DATAWIDTH-1:0]  dSrc,
  input  logic [PSRWIDTH-1:0]   psrIn,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATAWIDTH-1:0]  mem_addr,
  output logic                  write,
  output logic                  IMM_MUX,
  output logic                  SRAM_OUT,
  output logic                  RA_BUF,
  output logic [REGWIDTH-1:0]   rSrc,
  output logic [REGWIDTH-1:0]   rDst,
  output logic [ALUOPWIDTH-1:0] aluOp,
  output logic [DATAWIDTH-1:0]  imm,
  output logic [DATAWIDTH-1:0]  pc,
  output logic [PSRWIDTH-1:0]   psr,
  output logic                  err
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM} state_t;

  state_t                 state_q, state_d;
  logic [DATAWIDTH-1:0]   pc_q, pc_d;
  logic [DATAWIDTH-1:0]   ir_q, ir_d;
  logic [PSRWIDTH-1:0]    psr_q, psr_d;

  logic [3:0]             op, ext, cond;
  logic [DATAWIDTH-1:0]   imm_sext;
  logic                   abort_nop;
  logic                   is_rtype, is_itype, is_load, is_stor, is_jal, is_bcond;
  logic                   taken;

  assign op       = ir_q[15:12];
  assign ext      = ir_q[7:4];
  assign cond     = ir_q[11:8];
  assign imm_sext = {{(DATAWIDTH-8){ir_q[7]}}, ir_q[7:0]};

`ifdef CPU_CTRL_MEM_TIMEOUT_EN
  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              nop_q, nop_d;
  logic              err_q, err_d;
  logic              timeout;

  assign timeout   = !mem_ready && (wait_q == WAIT_W'(MEM_TIMEOUT - 1));
  assign abort_nop = nop_q;
  assign err       = err_q;
`else
  assign abort_nop = 1'b0;
  assign err       = 1'b0;
`endif

  // An aborted fetch leaves IR=0, which would otherwise decode as an RTYPE.
  assign is_rtype = (op == 4'h0) && !abort_nop;
  assign is_bcond = (op == 4'hC);
  assign is_itype = op[3] && !is_bcond;
  assign is_load  = (op == 4'h4) && (ext == 4'h0);
  assign is_stor  = (op == 4'h4) && (ext == 4'h4);
  assign is_jal   = (op == 4'h4) && (ext == 4'h8);

  always_comb begin
    case (cond)
      4'b0000: taken = psr_q[PSR_Z_BIT];
      4'b0001: taken = !psr_q[PSR_Z_BIT];
      4'b1110: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    psr_d   = psr_q;
`ifdef CPU_CTRL_MEM_TIMEOUT_EN
    wait_d  = wait_q;
    nop_d   = nop_q;
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
`ifdef CPU_CTRL_MEM_TIMEOUT_EN
        wait_d  = '0;
`endif
      end
      S_FETCH: begin
        if (mem_ready) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + DATAWIDTH'(1);
          state_d = S_DECODE;
`ifdef CPU_CTRL_MEM_TIMEOUT_EN
          nop_d   = 1'b0;
        end else if (timeout) begin
          ir_d    = '0;
          pc_d    = pc_q + DATAWIDTH'(1);
          nop_d   = 1'b1;
          err_d   = 1'b1;
          state_d = S_DECODE;
        end else begin
          wait_d  = wait_q + WAIT_W'(1);
`endif
        end
      end
      S_DECODE: begin
        if (is_load || is_stor) begin
          state_d = S_MEM;
`ifdef CPU_CTRL_MEM_TIMEOUT_EN
          wait_d  = '0;
`endif
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_rtype || is_itype) psr_d = psrIn;
        if (is_jal)               pc_d  = dSrc;
        if (is_bcond && taken)    pc_d  = pc_q + imm_sext;
        state_d = S_FETCH;
`ifdef CPU_CTRL_MEM_TIMEOUT_EN
        wait_d  = '0;
`endif
      end
      S_MEM: begin
        if (mem_ready) begin
          state_d = S_FETCH;
`ifdef CPU_CTRL_MEM_TIMEOUT_EN
          wait_d  = '0;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = S_FETCH;
          wait_d  = '0;
        end else begin
          wait_d  = wait_q + WAIT_W'(1);
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      psr_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      psr_q   <= psr_d;
    end
  end

`ifdef CPU_CTRL_MEM_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_q <= '0;
      nop_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      wait_q <= wait_d;
      nop_q  <= nop_d;
      err_q  <= err_d;
    end
  end
`endif

  // Strobes decode the registered state and IR so reset drops them immediately.
  always_comb begin
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_addr = pc_q;
    write    = 1'b0;
    IMM_MUX  = 1'b0;
    SRAM_OUT = 1'b0;
    RA_BUF   = 1'b0;
    case (state_q)
      S_FETCH: mem_req = 1'b1;
      S_EXEC: begin
        write   = is_rtype || is_itype || is_jal;
        IMM_MUX = is_itype;
        RA_BUF  = is_jal;
      end
      S_MEM: begin
        mem_req  = 1'b1;
        mem_addr = dSrc;
        mem_we   = is_stor;
        SRAM_OUT = is_load;
        write    = is_load && mem_ready;
      end
      default: ;
    endcase
  end

  assign rSrc  = ir_q[REGWIDTH-1:0];
  assign rDst  = ir_q[8 +: REGWIDTH];
  assign aluOp = is_itype ? ALUOPWIDTH'({1'b0, op[2:0]}) : ALUOPWIDTH'(ext);
  assign imm   = imm_sext;
  assign pc    = pc_q;
  assign psr   = psr_q;

endmodule

// File: tb/tb_cpu_ctrl.sv
// Directed bench for cpu_ctrl: an instruction-level model expands each instruction
// into its expected per-cycle bus/strobe trace, checked every cycle.
module tb_cpu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] mem_rdata, dSrc;
  logic        mem_ready;
  logic [4:0]  psrIn;
  logic        mem_req, mem_we, write, IMM_MUX, SRAM_OUT, RA_BUF, err;
  logic [15:0] mem_addr, imm, pc;
  logic [3:0]  rSrc, rDst, aluOp;
  logic [4:0]  psr;

  always #5 clk = ~clk;

  cpu_ctrl #(
    .DATAWIDTH(16), .REGWIDTH(4), .ALUOPWIDTH(4), .PSRWIDTH(5),
    .PSR_Z_BIT(3), .RESET_PC(16'h0000), .MEM_TIMEOUT(16)
  ) dut (
    .clk(clk), .reset(reset), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .dSrc(dSrc), .psrIn(psrIn), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .write(write), .IMM_MUX(IMM_MUX), .SRAM_OUT(SRAM_OUT),
    .RA_BUF(RA_BUF), .rSrc(rSrc), .rDst(rDst), .aluOp(aluOp), .imm(imm),
    .pc(pc), .psr(psr), .err(err)
  );

  typedef struct packed {
    logic        rdy;
    logic [15:0] rdata;
    logic [15:0] dsrc;
    logic [4:0]  psrin;
    logic        req, we;
    logic [15:0] addr;
    logic        wr, imux, sram, rab;
    logic        chk_ir;
    logic [3:0]  rs, rd;
    logic [15:0] immv;
    logic        chk_alu;
    logic [3:0]  alu;
    logic [15:0] pcv;
    logic [4:0]  psrv;
    logic        errv;
  } cyc_t;

  typedef enum {K_RT, K_IT, K_LD, K_ST, K_JAL, K_BR, K_NOP} kind_t;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  logic [15:0] m_pc;
  logic [4:0]  m_psr;
  logic        m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic kind_t kind_of(input logic [15:0] ins);
    logic [3:0] op, ext;
    op  = ins[15:12];
    ext = ins[7:4];
    if (op == 4'h0) return K_RT;
    if (op == 4'hC) return K_BR;
    if (op[3])      return K_IT;
    if (op == 4'h4 && ext == 4'h0) return K_LD;
    if (op == 4'h4 && ext == 4'h4) return K_ST;
    if (op == 4'h4 && ext == 4'h8) return K_JAL;
    return K_NOP;
  endfunction

  function automatic logic br_taken(input logic [3:0] c, input logic z);
    if (c == 4'b0000) return z;
    if (c == 4'b0001) return !z;
    if (c == 4'b1110) return 1'b1;
    return 1'b0;
  endfunction

  // Idle-bus cycle: mem_ready high and junk on data inputs, which must be ignored.
  function automatic cyc_t blank();
    cyc_t c;
    c       = '0;
    c.rdy   = 1'b1;
    c.rdata = 16'($urandom);
    c.psrin = 5'($urandom);
    c.pcv   = m_pc;
    c.psrv  = m_psr;
    c.errv  = m_err;
    return c;
  endfunction

  task automatic step(input cyc_t c);
    @(posedge clk);
    #1;
    mem_ready = c.rdy;
    mem_rdata = c.rdata;
    dSrc      = c.dsrc;
    psrIn     = c.psrin;
    @(negedge clk);
    chk("mem_req", mem_req, c.req);
    if (c.req) chk("mem_addr", mem_addr, c.addr);
    chk("mem_we", mem_we, c.we);
    chk("write", write, c.wr);
    chk("IMM_MUX", IMM_MUX, c.imux);
    chk("SRAM_OUT", SRAM_OUT, c.sram);
    chk("RA_BUF", RA_BUF, c.rab);
    chk("pc", pc, c.pcv);
    chk("psr", psr, c.psrv);
    chk("err", err, c.errv);
    if (c.chk_ir) begin
      chk("rSrc", rSrc, c.rs);
      chk("rDst", rDst, c.rd);
      chk("imm", imm, c.immv);
    end
    if (c.chk_alu) chk("aluOp", aluOp, c.alu);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_write", write, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    chk("idle_mem_req", mem_req, 1'b0);
    chk("idle_pc", pc, 16'h0000);
    chk("idle_psr", psr, 5'h00);
    chk("idle_err", err, 1'b0);
    m_pc  = 16'h0000;
    m_psr = 5'h00;
    m_err = 1'b0;
  endtask

  task automatic fill_ir(inout cyc_t c, input logic [15:0] ins);
    c.chk_ir = 1'b1;
    c.rs     = ins[3:0];
    c.rd     = ins[11:8];
    c.immv   = {{8{ins[7]}}, ins[7:0]};
  endtask

  task automatic issue(input logic [15:0] ins, input logic [15:0] ds, input logic [4:0] pin,
                       input int fw, input int mw);
    cyc_t  c;
    kind_t k;
    logic [15:0] se;
    k  = kind_of(ins);
    se = {{8{ins[7]}}, ins[7:0]};
    for (int i = 0; i <= fw; i++) begin
      c       = blank();
      c.rdy   = (i == fw);
      c.rdata = (i == fw) ? ins : 16'($urandom);
      c.dsrc  = ds;
      c.req   = 1'b1;
      c.addr  = m_pc;
      step(c);
    end
    m_pc = m_pc + 16'd1;
    c = blank();
    c.dsrc = ds;
    fill_ir(c, ins);
    step(c);
    if (k == K_LD || k == K_ST) begin
      for (int i = 0; i <= mw; i++) begin
        c      = blank();
        fill_ir(c, ins);
        c.rdy  = (i == mw);
        c.dsrc = ds;
        c.req  = 1'b1;
        c.addr = ds;
        c.we   = (k == K_ST);
        c.sram = (k == K_LD);
        c.wr   = (k == K_LD) && (i == mw);
        step(c);
      end
    end else begin
      c         = blank();
      fill_ir(c, ins);
      c.dsrc    = ds;
      c.psrin   = pin;
      c.wr      = (k == K_RT) || (k == K_IT) || (k == K_JAL);
      c.imux    = (k == K_IT);
      c.rab     = (k == K_JAL);
      c.chk_alu = (k == K_RT) || (k == K_IT);
      c.alu     = (k == K_IT) ? {1'b0, ins[14:12]} : ins[7:4];
      step(c);
      case (k)
        K_RT, K_IT: m_psr = pin;
        K_JAL:      m_pc  = ds;
        K_BR:       if (br_taken(ins[11:8], m_psr[3])) m_pc = m_pc + se;
        default: ;
      endcase
    end
  endtask

`ifdef CPU_CTRL_MEM_TIMEOUT_EN
  task automatic fetch_timeout();
    cyc_t c;
    for (int i = 0; i < 16; i++) begin
      c      = blank();
      c.rdy  = 1'b0;
      c.req  = 1'b1;
      c.addr = m_pc;
      step(c);
    end
    m_pc  = m_pc + 16'd1;
    m_err = 1'b1;
    c = blank();
    fill_ir(c, 16'h0000);
    step(c);
    c = blank();
    fill_ir(c, 16'h0000);
    step(c);
  endtask
`endif

  initial begin
    cyc_t c;
    reset = 1'b0; mem_ready = 1'b0; mem_rdata = '0; dSrc = '0; psrIn = '0;
    m_pc = '0; m_psr = '0; m_err = 1'b0;
    do_reset();

    // Reset while a fetch is still waiting.
    for (int i = 0; i < 2; i++) begin
      c = blank(); c.rdy = 1'b0; c.req = 1'b1; c.addr = m_pc;
      step(c);
    end
    do_reset();

    issue(16'h0152, 16'h1234, 5'h08, 0, 0);
    chk("lit_rtype_pc", pc, 16'h0001);
    chk("lit_rtype_psr", m_psr, 5'h08);
    issue(16'h93FF, 16'h0000, 5'h00, 0, 0);
    issue(16'h4702, 16'h0040, 5'h1F, 0, 2);
    issue(16'h4341, 16'h0055, 5'h1F, 1, 1);
    issue(16'h4F90, 16'h0000, 5'h1F, 0, 0);
    issue(16'hC5FE, 16'h0000, 5'h1F, 0, 0);
    chk("lit_never_pc", m_pc, 16'h0006);
    issue(16'h4E85, 16'h0010, 5'h1F, 0, 0);
    issue(16'h4E85, 16'h0100, 5'h1F, 0, 0);
    chk("lit_jal_ra_pc", pc, 16'h0011);
    chk("lit_jal_target", m_pc, 16'h0100);
    issue(16'h4E85, 16'h001F, 5'h1F, 0, 0);
    issue(16'h0152, 16'h0000, 5'h08, 0, 0);
    issue(16'hC0FE, 16'h0000, 5'h00, 0, 0);
    chk("lit_bz_taken", m_pc, 16'h001F);
    issue(16'h0152, 16'h0000, 5'h00, 0, 0);
    issue(16'hC0FE, 16'h0000, 5'h08, 0, 0);
    chk("lit_bz_not_taken", m_pc, 16'h0021);
    issue(16'hC102, 16'h0000, 5'h08, 0, 0);
    chk("lit_bnz_taken", m_pc, 16'h0024);
    issue(16'hEEFE, 16'h0000, 5'h04, 0, 0);
    issue(16'hCE03, 16'h0000, 5'h1F, 0, 0);
    chk("lit_bal_taken", m_pc, 16'h0029);
    issue(16'h4E85, 16'hFFFF, 5'h1F, 0, 0);
    issue(16'h4F90, 16'h0000, 5'h1F, 2, 0);
    chk("lit_pc_wrap", pc, 16'h0000);
`ifdef CPU_CTRL_MEM_TIMEOUT_EN
    fetch_timeout();
    chk("lit_timeout_err", err, 1'b1);
    chk("lit_timeout_pc", pc, 16'h0001);
    issue(16'h0152, 16'h0000, 5'h02, 0, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
